// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions.
// MDU op codes, FSM states and iteration count.
package mips_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO.
// One 64-bit accumulator serves both shift-add and shift-subtract.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MDU_ITERS);
  localparam logic [CW-1:0] LAST = CW'(MDU_ITERS - 1);

  mdu_state_t state, state_n;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   a_raw;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic               fix_ph;

  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // Operand magnitudes, per-iteration arithmetic, sign fixup
  always_comb begin
    sgn_op   = ~op[0];
    a_neg    = sgn_op & opa[WIDTH-1];
    b_neg    = sgn_op & opb[WIDTH-1];
    a_mag    = a_neg ? -opa : opa;
    b_mag    = b_neg ? -opb : opb;
    acc_hi   = acc[2*WIDTH-1:WIDTH];
    acc_lo   = acc[WIDTH-1:0];
    mul_sum  = {1'b0, acc_hi} + {1'b0, addend};
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, addend};
    fixed    = acc;
    if (!is_div) begin
      if (neg_q) fixed = -acc;
    end else if (b_zero) begin
      fixed = {a_raw, {WIDTH{1'b1}}};
    end else begin
      fixed = {neg_r ? -acc_hi : acc_hi,
               neg_q ? -acc_lo : acc_lo};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == LAST) state_n = FIX;
      FIX:     if (fix_ph) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath, operand latch and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      addend      <= '0;
      a_raw       <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      fix_ph      <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            a_raw       <= opa;
            b_zero      <= (opb == '0);
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            cnt         <= '0;
            fix_ph      <= 1'b0;
            div_by_zero <= 1'b0;
            if (op[1]) begin
              acc    <= {{WIDTH{1'b0}}, a_mag};
              addend <= b_mag;
            end else begin
              acc    <= {{WIDTH{1'b0}}, b_mag};
              addend <= a_mag;
            end
          end else begin
            if (mthi) hi <= opa;
            if (mtlo) lo <= opa;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH])
              acc <= {div_diff[WIDTH-1:0],
                      acc[WIDTH-2:0], 1'b1};
            else
              acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (acc[0])
              acc <= {mul_sum, acc[WIDTH-1:1]};
            else
              acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!fix_ph) begin
            acc    <= fixed;
            fix_ph <= 1'b1;
          end else begin
            hi          <= acc_hi;
            lo          <= acc_lo;
            div_by_zero <= is_div & b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Directed table, random ops vs model, corner sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed;
  } vec_t;

  vec_t vecs[9];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc, output bit bok);
    cyc = 0;
    bok = 1'b1;
    while (!done && cyc < 60) begin
      if (!busy) bok = 1'b0;
      step;
      cyc++;
    end
  endtask

  task automatic finish_check(string nm, int cyc, bit bok,
                              logic [31:0] eh, logic [31:0] el,
                              logic ed);
    chk({nm, " latency"}, 64'(cyc), 64'd34);
    chk({nm, " busy"}, {63'd0, bok}, 64'd1);
    chk({nm, " busy@done"}, {63'd0, busy}, 64'd0);
    chk({nm, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, lo}, {32'd0, el});
    chk({nm, " dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
    step;
    chk({nm, " pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(string nm, logic [1:0] o,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] eh, logic [31:0] el,
                        logic ed, bit scramble);
    int cyc;
    bit bok;
    op = o; opa = a; opb = b; start = 1'b1;
    step;
    start = 1'b0;
    if (scramble) begin
      opa = $urandom; opb = $urandom; op = 2'($urandom);
    end
    wait_done(cyc, bok);
    finish_check(nm, cyc, bok, eh, el, ed);
  endtask

  task automatic model(input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ed);
    longint p;
    longint unsigned up;
    ed = 1'b0;
    case (o)
      2'b00: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (b == 0) begin
          el = 32'hFFFFFFFF; eh = a; ed = 1'b1;
        end else if (o == 2'b10 && a == 32'h80000000 &&
                     b == 32'hFFFFFFFF) begin
          el = 32'h80000000; eh = 32'h0;
        end else if (o == 2'b10) begin
          el = $signed(a) / $signed(b);
          eh = $signed(a) % $signed(b);
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  initial begin
    int cyc;
    bit bok;
    logic [31:0] eh, el;
    logic ed;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    vecs[0] = '{"mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5,
                32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{"div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{"div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000, 1'b0};
    vecs[4] = '{"div_100dm7", 2'b10, 32'd100, 32'hFFFFFFF9,
                32'd2, 32'hFFFFFFF2, 1'b0};
    vecs[5] = '{"divu_100d7", 2'b11, 32'd100, 32'd7,
                32'd2, 32'd14, 1'b0};
    vecs[6] = '{"mult_minmax", 2'b00, 32'h7FFFFFFF, 32'h80000000,
                32'hC0000000, 32'h80000000, 1'b0};
    vecs[7] = '{"div_dz", 2'b10, 32'hFFFFFFF9, 32'd0,
                32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{"divu_dz", 2'b11, 32'h1234, 32'd0,
                32'h1234, 32'hFFFFFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; op = 2'b00;
    opa = '0; opb = '0; mthi = 1'b0; mtlo = 1'b0;
    step; step;
    rst = 1'b0;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst hi", {32'd0, hi}, 64'd0);
    chk("rst lo", {32'd0, lo}, 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, vecs[i].ed, 1'b1);

    step; step; step;
    chk("dbz hold", {63'd0, div_by_zero}, 64'd1);
    op = 2'b01; opa = 32'd1; opb = 32'd1;
    start = 1'b1; mthi = 1'b1;
    step;
    start = 1'b0; mthi = 1'b0;
    chk("start+mthi hi", {32'd0, hi}, 64'h1234);
    chk("dbz clr", {63'd0, div_by_zero}, 64'd0);
    wait_done(cyc, bok);
    finish_check("multu_1x1", cyc, bok, 32'd0, 32'd1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      model(ro, ra, rb, eh, el, ed);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed, 1'b1);
    end

    op = 2'b01; opa = 32'd6; opb = 32'd7; start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 9; i++) step;
    op = 2'b11; opa = 32'hDEAD; start = 1'b1; mthi = 1'b1;
    step;
    start = 1'b0; mthi = 1'b0;
    wait_done(cyc, bok);
    finish_check("busy_ign", cyc + 10, bok, 32'd0, 32'd42, 1'b0);
    opa = 32'hBEEF; mtlo = 1'b1;
    step;
    mtlo = 1'b0;
    chk("mtlo lo", {32'd0, lo}, 64'hBEEF);
    chk("mtlo hi", {32'd0, hi}, 64'd0);
    opa = 32'hCAFE; mthi = 1'b1; mtlo = 1'b1;
    step;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo hi", {32'd0, hi}, 64'hCAFE);
    chk("mthilo lo", {32'd0, lo}, 64'hCAFE);

    op = 2'b10; opa = 32'd1000; opb = 32'd3; start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 14; i++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst hi", {32'd0, hi}, 64'd0);
    chk("midrst lo", {32'd0, lo}, 64'd0);
    run_op("mult_2x3", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU. Sits in the execute stage directly downstream of the register file. Consumes the rs/rt read data (rdata0/rdata1) for MULT, MULTU, DIV and DIVU, plus MTHI and MTLO. Its hi/lo outputs feed the MFHI/MFLO writeback path back into the register file; the busy output stalls the pipeline.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  synchronous, active-high reset
start  input  1  accept a new operation; sampled only when busy=0
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opa  input  32  rs operand (multiplicand / dividend)
opb  input  32  rt operand (multiplier / divisor)
mthi  input  1  write opa into HI
mtlo  input  1  write opa into LO
busy  output  1  operation in progress; pipeline stalls any MFHI/MFLO/MULT/DIV while high
done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle
div_by_zero  output  1  valid with done; set when a DIV/DIVU had opb=0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: state=IDLE; busy=0; done=0; div_by_zero=0; hi=0; lo=0. A reset mid-operation aborts it; no partial result is written.
- FSM states:
  - IDLE: start=1 latches op, |opa|, |opb| and the result sign. Magnitudes are taken only for signed ops. Next state CALC; iteration counter=0.
  - CALC: 32 iterations, one per cycle, counter 0..31.
    - Multiply: 64-bit shift-add on magnitudes.
    - Divide: restoring shift-subtract; yields a 32-bit quotient and remainder.
    - Next state FIX after counter=31.
  - FIX: apply the signs and write hi/lo. For signed ops, a negative product is two's-complemented over 64 bits. Next state DONE.
  - DONE: done=1 for one cycle; next state IDLE.
- Latency: start accepted at edge k gives busy=1 in the cycles after edges k through k+33, and done=1 in the cycle after edge k+34. busy is 0 during the done cycle.
- Multiply result: {hi,lo} = 64-bit product. MULT is signed; MULTU is unsigned.
- Divide result: lo=quotient, hi=remainder. For DIV, the quotient truncates toward zero and the remainder takes the sign of the dividend.
- Divide by zero (opb=0): lo=0xFFFFFFFF, hi=opa, div_by_zero=1 with done. The operation still takes the full latency.
- DIV overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, div_by_zero=0.
- start while busy=1: ignored; no queueing.
- mthi/mtlo:
  - Effective only in IDLE with start=0; written at the next edge.
  - Ignored in CALC, FIX and DONE.
  - mthi and mtlo together write opa to both registers.
- start together with mthi/mtlo in IDLE: start wins; mthi/mtlo are ignored.
- div_by_zero holds its value until the next accepted start, which clears it.
- Inputs are sampled only on the start edge; changes to opa/opb during CALC have no effect.

Decomposition:
- Shared package mips_pkg:
  - MDU op encodings: MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - FSM state encoding: IDLE, CALC, FIX, DONE.
  - Constant MDU_ITERS=32.
- Sub-module: none. The shift-add and shift-subtract datapath shares one 64-bit accumulator register inside mult_div_unit.

Test Plan:
- MULT opa=0xFFFFFFFD (-3), opb=5 -> done after 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opa=0x1234, opb=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 in the done cycle.
- MULTU 6*7 started; at cycle 10 assert start (DIVU) and mthi with opa=0xDEAD -> both ignored. Result hi=0, lo=42. A later idle mtlo with opa=0xBEEF -> lo=0xBEEF at the next edge, hi unchanged.
- DIV started; rst=1 at cycle 15 -> next cycle busy=0, done=0, hi=lo=0. A new MULT of 2*3 then completes with lo=6 after 34 cycles.
